// File: rtl/iis_tx_arb.sv
// rtl/iis_tx_arb.sv - two-producer round-robin burst arbiter for the IIS TX FIFO write port
// Define IIS_TX_ARB_PRIO_EN for fixed priority (producer 0 wins whenever eligible).
module iis_tx_arb #(
    parameter int DATA_W = 16,
    parameter int BURST  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              arb_en,
    input  logic [1:0]        ch_en,
    input  logic              cnt_clr,
    input  logic [1:0]        req_valid,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    input  logic              fifo_full,
    output logic              fifo_wren,
    output logic [DATA_W-1:0] fifo_din,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              burst_done,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAST = 8'(BURST - 1);

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               rr_last_q, rr_last_d;
    logic [7:0]         bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               done_q, done_d;
    logic [1:0]         eligible;
    logic [1:0]         pick;
    logic               gsel;
    logic               xfer;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            rr_last_q  <= 1'b1;
            bcnt_q     <= 8'd0;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            bcnt_q     <= bcnt_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        eligible   = req_valid & ch_en;
        gsel       = grant_q[1];
        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        bcnt_d     = bcnt_q;
        done_d     = 1'b0;
        xfer       = 1'b0;
        req_ready  = 2'b00;
        fifo_wren  = 1'b0;
        fifo_din   = gsel ? req_data1 : req_data0;
`ifdef IIS_TX_ARB_PRIO_EN
        pick = eligible[0] ? 2'b01 : 2'b10;
`else
        // With both eligible the one not served last wins; otherwise the lone one.
        if (eligible == 2'b11)
            pick = rr_last_q ? 2'b01 : 2'b10;
        else
            pick = eligible[0] ? 2'b01 : 2'b10;
`endif
        case (state_q)
            IDLE: begin
                if (arb_en && (|eligible)) begin
                    state_d = BUSY;
                    grant_d = pick;
                    bcnt_d  = 8'd0;
                end
            end
            BUSY: begin
                xfer = arb_en & ch_en[gsel] & req_valid[gsel] & ~fifo_full;
                if (xfer) begin
                    fifo_wren = 1'b1;
                    req_ready = grant_q;
                    bcnt_d    = bcnt_q + 8'd1;
                end
                // A full FIFO alone never ends the burst; it only stalls it.
                if ((xfer && bcnt_q == LAST) || !req_valid[gsel] || !arb_en || !ch_en[gsel]) begin
                    state_d   = IDLE;
                    grant_d   = 2'b00;
                    rr_last_d = gsel;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cnt_clr)
            word_cnt_d = '0;
        else if (xfer)
            word_cnt_d = word_cnt_q + 1'b1;
        else
            word_cnt_d = word_cnt_q;
    end

    assign grant      = grant_q;
    assign busy       = (state_q == BUSY);
    assign burst_done = done_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_iis_tx_arb.sv
// tb/tb_iis_tx_arb.sv - scoreboard testbench for iis_tx_arb
module tb_iis_tx_arb;

    logic        clk = 1'b0;
    logic        presetn;
    logic        arb_en;
    logic [1:0]  ch_en;
    logic        cnt_clr;
    logic [1:0]  req_valid;
    logic [15:0] req_data0, req_data1;
    logic        fifo_full;
    logic [1:0]  req_ready, grant;
    logic        fifo_wren, busy, burst_done;
    logic [15:0] fifo_din;
    logic [31:0] word_cnt;
    logic [1:0]  w_ready, w_grant;
    logic        w_wren, w_busy, w_done;
    logic [15:0] w_din;
    logic [2:0]  w_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          idx0, idx1;
    logic [15:0] base0, base1;
    logic [1:0]  s_ready, s_grant;
    logic        s_wren, s_busy, s_done;
    logic [15:0] s_din;
    logic [31:0] s_cnt;
    logic [2:0]  s_wcnt;

    always #5 clk = ~clk;

    iis_tx_arb #(.DATA_W(16), .BURST(4), .CNT_W(32)) dut (
        .pclk(clk), .presetn(presetn), .arb_en(arb_en), .ch_en(ch_en), .cnt_clr(cnt_clr),
        .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wren(fifo_wren),
        .fifo_din(fifo_din), .grant(grant), .busy(busy), .burst_done(burst_done),
        .word_cnt(word_cnt)
    );

    iis_tx_arb #(.DATA_W(16), .BURST(4), .CNT_W(3)) u_wrap (
        .pclk(clk), .presetn(presetn), .arb_en(arb_en), .ch_en(ch_en), .cnt_clr(cnt_clr),
        .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(w_ready), .fifo_full(fifo_full), .fifo_wren(w_wren),
        .fifo_din(w_din), .grant(w_grant), .busy(w_busy), .burst_done(w_done),
        .word_cnt(w_cnt)
    );

    task automatic apply_reset();
        presetn   = 1'b0;
        arb_en    = 1'b0;
        ch_en     = 2'b00;
        cnt_clr   = 1'b0;
        req_valid = 2'b00;
        fifo_full = 1'b0;
        idx0 = 0;
        idx1 = 0;
        base0 = 16'h0000;
        base1 = 16'h0000;
        req_data0 = 16'h0000;
        req_data1 = 16'h0000;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge clk);
        #1 presetn = 1'b1;
    endtask

    task automatic set_bases(input logic [15:0] b0, input logic [15:0] b1);
        base0 = b0;
        base1 = b1;
        req_data0 = b0;
        req_data1 = b1;
    endtask

    // Sample outputs at the negedge, then let the producers advance past the posedge.
    task automatic step();
        @(negedge clk);
        s_ready = req_ready;
        s_grant = grant;
        s_wren  = fifo_wren;
        s_busy  = busy;
        s_done  = burst_done;
        s_din   = fifo_din;
        s_cnt   = word_cnt;
        s_wcnt  = w_cnt;
        if (fifo_wren) obs_q.push_back(fifo_din);
        @(posedge clk);
        #1;
        if (s_ready[0]) idx0++;
        if (s_ready[1]) idx1++;
        req_data0 = base0 + 16'(idx0);
        req_data1 = base1 + 16'(idx1);
    endtask

    task automatic test_reset();
        presetn   = 1'b0;
        arb_en    = 1'b1;
        ch_en     = 2'b11;
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (fifo_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", fifo_wren); end
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", burst_done); end
        checks++; if (word_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", word_cnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] eg;
        apply_reset();
        set_bases(16'h1000, 16'h2000);
        arb_en = 1'b1; ch_en = 2'b11; req_valid = 2'b11;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(16'h1000 + 16'(4*r + i));
            for (int i = 0; i < 4; i++) exp_q.push_back(16'h2000 + 16'(4*r + i));
        end
        step();
        for (int k = 1; k <= 20; k++) begin
            step();
            eg = (k % 5 == 0) ? 2'b00 : ((((k - 1) / 5) % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (s_grant !== eg) begin errors++; $display("FAIL rr_grant k=%0d got %b exp %b", k, s_grant, eg); end
            checks++; if (s_done !== (k % 5 == 0)) begin errors++; $display("FAIL rr_done k=%0d got %b", k, s_done); end
            if (k == 10) begin
                checks++; if (s_cnt !== 32'd8) begin errors++; $display("FAIL rr_cnt10 got %0d exp 8", s_cnt); end
            end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_nwrites got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_single_producer();
        int ndone;
        apply_reset();
        set_bases(16'h0000, 16'hA001);
        arb_en = 1'b1; ch_en = 2'b11; req_valid = 2'b10;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'hA001 + 16'(i));
        ndone = 0;
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (s_done) ndone++;
            if (idx1 == 3) req_valid = 2'b00;
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL single_done got %0d exp 1", ndone); end
        checks++; if (s_cnt !== 32'd3) begin errors++; $display("FAIL single_cnt got %0d exp 3", s_cnt); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_nwrites got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        set_bases(16'h3000, 16'h0000);
        arb_en = 1'b1; ch_en = 2'b11; req_valid = 2'b01;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h3000 + 16'(i));
        step();
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k >= 3 && k <= 8) begin
                checks++; if (s_grant !== 2'b01 || s_wren !== 1'b0 || s_ready !== 2'b00)
                    begin errors++; $display("FAIL full_hold k=%0d got grant %b wren %b ready %b exp 01 0 00", k, s_grant, s_wren, s_ready); end
            end
            if (k == 2) fifo_full = 1'b1;
            if (k == 8) fifo_full = 1'b0;
        end
        checks++; if (s_grant !== 2'b00 || s_done !== 1'b1) begin errors++; $display("FAIL full_end got grant %b done %b exp 00 1", s_grant, s_done); end
        checks++; if (s_cnt !== 32'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", s_cnt); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL full_nwrites got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_data[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_arb_en_drop();
        apply_reset();
        set_bases(16'h4000, 16'h0000);
        arb_en = 1'b1; ch_en = 2'b11; req_valid = 2'b01;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h4000 + 16'(i));
        step();
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 3) begin
                checks++; if (s_busy !== 1'b1 || s_grant !== 2'b01 || s_wren !== 1'b0)
                    begin errors++; $display("FAIL dis_cycle got busy %b grant %b wren %b exp 1 01 0", s_busy, s_grant, s_wren); end
            end
            if (k == 4) begin
                checks++; if (s_grant !== 2'b00 || s_done !== 1'b1 || s_cnt !== 32'd2)
                    begin errors++; $display("FAIL dis_idle got grant %b done %b cnt %0d exp 00 1 2", s_grant, s_done, s_cnt); end
            end
            if (k >= 5 && k <= 8) begin
                checks++; if (s_busy !== 1'b0 || s_grant !== 2'b00) begin errors++; $display("FAIL dis_nogrant k=%0d got busy %b grant %b", k, s_busy, s_grant); end
            end
            if (k == 9) begin
                checks++; if (s_grant !== 2'b01 || s_wren !== 1'b1) begin errors++; $display("FAIL dis_resume got grant %b wren %b exp 01 1", s_grant, s_wren); end
            end
            if (k == 2) arb_en = 1'b0;
            if (k == 7) arb_en = 1'b1;
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL dis_nwrites got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL dis_data[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cnt_wrap_clr();
        logic seen7, seen8, found;
        apply_reset();
        set_bases(16'h5000, 16'h0000);
        arb_en = 1'b1; ch_en = 2'b01; req_valid = 2'b01;
        seen7 = 1'b0; seen8 = 1'b0;
        for (int k = 0; k < 60 && !seen8; k++) begin
            step();
            if (s_cnt == 32'd7 && !seen7) begin
                seen7 = 1'b1;
                checks++; if (s_wcnt !== 3'd7) begin errors++; $display("FAIL wrap_pre got %0d exp 7", s_wcnt); end
            end
            if (s_cnt == 32'd8) begin
                seen8 = 1'b1;
                checks++; if (s_wcnt !== 3'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", s_wcnt); end
            end
        end
        checks++; if (!seen8) begin errors++; $display("FAIL wrap_timeout got cnt %0d exp 8", s_cnt); end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (fifo_wren) found = 1'b1;
            else step();
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        #1;
        checks++; if (s_wren !== 1'b1) begin errors++; $display("FAIL clr_write got wren %b exp 1", s_wren); end
        checks++; if (word_cnt !== 32'd0 || w_cnt !== 3'd0) begin errors++; $display("FAIL clr_cnt got %0d/%0d exp 0/0", word_cnt, w_cnt); end
    endtask

`ifdef IIS_TX_ARB_PRIO_EN
    task automatic test_prio();
        logic found;
        apply_reset();
        set_bases(16'h6000, 16'h7000);
        arb_en = 1'b1; ch_en = 2'b11; req_valid = 2'b11;
        step();
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++; if (s_grant !== ((k % 5 == 0) ? 2'b00 : 2'b01)) begin errors++; $display("FAIL prio_grant k=%0d got %b", k, s_grant); end
        end
        req_valid = 2'b10;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (s_grant == 2'b10) found = 1'b1;
        end
        checks++; if (!found || s_din !== 16'h7000) begin errors++; $display("FAIL prio_p1 got found %b din %h exp 1 7000", found, s_din); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef IIS_TX_ARB_PRIO_EN
        test_prio();
`else
        test_round_robin();
`endif
        test_single_producer();
        test_fifo_full();
        test_arb_en_drop();
        test_cnt_wrap_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
